// File: rtl/matmul_apb_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_apb_slave                                                 |
// | Purpose  : APB slave front-end for the matmul accelerator. Decodes a small  |
// |            register map (CTRL, STATUS) and a word-addressed operand/result |
// |            memory window, inserts programmable wait states, applies byte   |
// |            strobes to memory writes and generates slave errors.            |
// | Ports    : clk_i/rst_i        clock, synchronous active-high reset         |
// |            psel_i..paddr_i    APB request (setup + access phases)          |
// |            pready_o/pslverr_o/prdata_o  APB completion response            |
// |            start_o/busy_o/busy_i        engine start pulse and busy status |
// |            mem_*              1-cycle-latency memory port (window)         |
// | Options  : MATMUL_APB_PROT_EN - reject CTRL start and memory-window writes |
// |            with pslverr_o while busy_o is high.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module matmul_apb_slave #(
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int STRB_WIDTH  = BUS_WIDTH / 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [STRB_WIDTH-1:0]        pstrb_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  output logic                         busy_o,
  output logic                         start_o,
  input  logic                         busy_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [STRB_WIDTH-1:0]        mem_be_o,
  output logic [BUS_WIDTH-1:0]         mem_wdata_o,
  input  logic [BUS_WIDTH-1:0]         mem_rdata_i
);

  localparam int MAW    = $clog2(MEM_DEPTH);
  localparam int BSHIFT = $clog2(STRB_WIDTH);
  // Access cycle in which pready_o is high; memory reads need at least two
  // cycles because the read data arrives the cycle after the request.
  localparam logic [4:0] BASE_N = 5'(WAIT_STATES + 1);
  localparam logic [4:0] READ_N = (WAIT_STATES == 0) ? 5'd2 : BASE_N;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [4:0]              target_q, target_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [BUS_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    rd_mem_q, rd_mem_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [BUS_WIDTH-1:0]    rd_hold_q, rd_hold_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [MAW-1:0]          mem_addr_q, mem_addr_d;
  logic [STRB_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [BUS_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  // Effective transfer attributes: taken straight from the bus in IDLE (the
  // setup cycle) and from the captured copy once in ACCESS.
  logic                    setup;
  logic [ADDR_WIDTH-1:0]   eff_idx;
  logic                    eff_wr;
  logic [BUS_WIDTH-1:0]    eff_wdata;
  logic [STRB_WIDTH-1:0]   eff_strb;
  logic                    is_ctrl, is_status, is_mem, is_oor;
  logic                    start_req, mem_rd, prot_err, new_err, eff_err;
  logic [4:0]              new_target;
  logic [MAW-1:0]          eff_maddr;
  logic                    fire;

  always_comb begin
    setup     = psel_i & ~penable_i;
    eff_idx   = (state_q == IDLE) ? (paddr_i >> BSHIFT) : idx_q;
    eff_wr    = (state_q == IDLE) ? pwrite_i : wr_q;
    eff_wdata = (state_q == IDLE) ? pwdata_i : wdata_q;
    eff_strb  = (state_q == IDLE) ? pstrb_i  : strb_q;

    is_ctrl   = (eff_idx == ADDR_WIDTH'(0));
    is_status = (eff_idx == ADDR_WIDTH'(1));
    is_oor    = (eff_idx >= ADDR_WIDTH'(MEM_DEPTH + 2));
    is_mem    = (eff_idx >= ADDR_WIDTH'(2)) & ~is_oor;
    eff_maddr = MAW'(eff_idx - ADDR_WIDTH'(2));

    start_req = is_ctrl & eff_wr & eff_strb[0] & eff_wdata[0];
    mem_rd    = is_mem & ~eff_wr;
`ifdef MATMUL_APB_PROT_EN
    prot_err  = busy_q & eff_wr & (start_req | is_mem);
`else
    prot_err  = 1'b0;
`endif
    new_err    = is_oor | (is_status & eff_wr) | prot_err;
    eff_err    = (state_q == IDLE) ? new_err : err_q;
    new_target = mem_rd ? READ_N : BASE_N;

    // Completion edge: either straight out of setup (single-cycle access) or
    // at the end of access cycle N-1 while the master still holds the bus.
    fire = ((state_q == IDLE) & setup & (new_target == 5'd1)) |
           ((state_q == ACCESS) & ~pready_q & psel_i & penable_i &
            ((cnt_q + 5'd1) == target_q));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    err_d       = err_q;
    rd_mem_d    = rd_mem_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    rd_hold_d   = rd_hold_q;
    start_d     = 1'b0;
    busy_d      = busy_i | start_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = ACCESS;
          cnt_d    = 5'd1;
          target_d = new_target;
          idx_d    = eff_idx;
          wr_d     = pwrite_i;
          wdata_d  = pwdata_i;
          strb_d   = pstrb_i;
          err_d    = new_err;
          rd_mem_d = mem_rd;
          // Memory reads are issued in the first access cycle.
          if (mem_rd) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = eff_maddr;
            mem_be_d   = '1;
          end
        end
      end
      ACCESS: begin
        if (pready_q || !(psel_i && penable_i)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data lands one cycle after the request (access cycle 2).
    if ((state_q == ACCESS) && (cnt_q == 5'd2) && rd_mem_q) begin
      rd_hold_d = mem_rdata_i;
    end

    if (fire) begin
      pready_d  = 1'b1;
      pslverr_d = eff_err;
      if (!(mem_rd && !eff_err)) begin
        rd_hold_d = (is_status && !eff_wr && !eff_err) ?
                    {{(BUS_WIDTH-1){1'b0}}, busy_q} : '0;
      end
      if (!eff_err && eff_wr) begin
        if (start_req) begin
          start_d = 1'b1;
        end
        // Writes commit at completion; an all-zero strobe is a no-op.
        if (is_mem && (eff_strb != '0)) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = eff_maddr;
          mem_be_d    = eff_strb;
          mem_wdata_d = eff_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      rd_mem_q    <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      rd_hold_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      rd_mem_q    <= rd_mem_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      rd_hold_q   <= rd_hold_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  // A two-cycle memory read completes in the same cycle its data arrives, so
  // that case forwards mem_rdata_i; every other response uses the held value.
  assign prdata_o    = (pready_q && !pslverr_q) ?
                       ((rd_mem_q && (cnt_q == 5'd2)) ? mem_rdata_i : rd_hold_q) : '0;
  assign busy_o      = busy_q;
  assign start_o     = start_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matmul_apb_slave                                              |
// | Purpose  : Directed self-checking bench for matmul_apb_slave. Instance     |
// |            dut0 has WAIT_STATES=0 and a byte-enabled RAM model; dut3 has   |
// |            WAIT_STATES=3 and a fixed memory read value.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_matmul_apb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic [15:0] paddr = 16'h0;
  logic        busy_in = 1'b0;

  logic        pready0, pslverr0, busyo0, start0, mreq0, mwe0;
  logic [31:0] prdata0, mwdata0, rdata0;
  logic [5:0]  maddr0;
  logic [3:0]  mbe0;
  logic        pready3, pslverr3, busyo3, start3, mreq3, mwe3;
  logic [31:0] prdata3, mwdata3;
  logic [31:0] rdata3 = 32'h1234_5678;
  logic [5:0]  maddr3;
  logic [3:0]  mbe3;

  int checks = 0;
  int errors = 0;
  logic sel = 1'b0;   // 0 -> dut0, 1 -> dut3

  always #5 clk = ~clk;

  matmul_apb_slave #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
    .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .pready_o(pready0),
    .pslverr_o(pslverr0), .prdata_o(prdata0), .busy_o(busyo0), .start_o(start0),
    .busy_i(busy_in), .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_addr_o(maddr0),
    .mem_be_o(mbe0), .mem_wdata_o(mwdata0), .mem_rdata_i(rdata0));

  matmul_apb_slave #(.WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
    .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .pready_o(pready3),
    .pslverr_o(pslverr3), .prdata_o(prdata3), .busy_o(busyo3), .start_o(start3),
    .busy_i(busy_in), .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3),
    .mem_be_o(mbe3), .mem_wdata_o(mwdata3), .mem_rdata_i(rdata3));

  // Byte-enabled RAM behind dut0, data returned the cycle after a read request.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[63] <= 32'hCAFE_F00D;
      rdata0  <= 32'h0;
    end else if (mreq0) begin
      if (mwe0) begin
        for (int b = 0; b < 4; b++)
          if (mbe0[b]) ram[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
      end else begin
        rdata0 <= ram[maddr0];
      end
    end
  end

  wire        c_pready  = sel ? pready3  : pready0;
  wire        c_pslverr = sel ? pslverr3 : pslverr0;
  wire [31:0] c_prdata  = sel ? prdata3  : prdata0;
  wire        c_start   = sel ? start3   : start0;
  wire        c_busy    = sel ? busyo3   : busyo0;
  wire        c_mreq    = sel ? mreq3    : mreq0;
  wire        c_mwe     = sel ? mwe3     : mwe0;
  wire [5:0]  c_maddr   = sel ? maddr3   : maddr0;
  wire [3:0]  c_mbe     = sel ? mbe3     : mbe0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One complete APB transfer; reports the access cycle of pready_o (0 if it
  // never came), the response, any memory request seen and any start pulse.
  task automatic apb(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int cyc, output logic err,
                     output logic [31:0] rd, output logic mreq, output logic mwe,
                     output logic [5:0] maddr, output logic [3:0] mbe,
                     output logic st, output logic ppready, output logic pbusy);
    bit done;
    cyc = 0; err = 0; rd = 0; mreq = 0; mwe = 0; maddr = 0; mbe = 0; st = 0; done = 0;
    @(posedge clk); #1;
    if (sel) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 20 && !done; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (c_mreq) begin mreq = 1; mwe = c_mwe; maddr = c_maddr; mbe = c_mbe; end
      if (c_start) st = 1;
      if (c_pready) begin done = 1; cyc = k; err = c_pslverr; rd = c_prdata; end
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    ppready = c_pready;
    pbusy   = c_busy;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: got no pready, expected pready within 20 cycles");
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          cyc;
    logic        err;
    logic [31:0] rd;
    logic        mreq;
    logic        mwe;
    logic [5:0]  maddr;
    logic [3:0]  mbe;
    logic        st;
  } vec_t;

  vec_t vt [14];

  int          cyc;
  logic        err, mreq, mwe, st, ppready, pbusy, seen;
  logic [31:0] rd;
  logic [5:0]  maddr;
  logic [3:0]  mbe;

  initial begin
    //           wr    addr      data           strb     cyc err rd             mreq  mwe  maddr mbe      st
    vt[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'b0011, 1, 1'b0, 32'h0,        1'b1, 1'b1, 6'd0,  4'b0011, 1'b0};
    vt[1]  = '{1'b0, 16'h0008, 32'h0,        4'b0000, 2, 1'b0, 32'h0000BEEF, 1'b1, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[2]  = '{1'b1, 16'h000C, 32'h11223344, 4'b1111, 1, 1'b0, 32'h0,        1'b1, 1'b1, 6'd1,  4'b1111, 1'b0};
    vt[3]  = '{1'b0, 16'h000E, 32'h0,        4'b0000, 2, 1'b0, 32'h11223344, 1'b1, 1'b0, 6'd1,  4'b0000, 1'b0};
    vt[4]  = '{1'b1, 16'h0008, 32'hAABBCCDD, 4'b1100, 1, 1'b0, 32'h0,        1'b1, 1'b1, 6'd0,  4'b1100, 1'b0};
    vt[5]  = '{1'b0, 16'h0008, 32'h0,        4'b0000, 2, 1'b0, 32'hAABBBEEF, 1'b1, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[6]  = '{1'b0, 16'h0108, 32'h0,        4'b0000, 1, 1'b1, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[7]  = '{1'b1, 16'h0004, 32'hFFFFFFFF, 4'b1111, 1, 1'b1, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[8]  = '{1'b0, 16'h0000, 32'h0,        4'b0000, 1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[9]  = '{1'b0, 16'h0004, 32'h0,        4'b0000, 1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[10] = '{1'b1, 16'h0008, 32'h12345678, 4'b0000, 1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};
    vt[11] = '{1'b0, 16'h0104, 32'h0,        4'b0000, 2, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 6'd63, 4'b0000, 1'b0};
    vt[12] = '{1'b1, 16'h0000, 32'h00000001, 4'b0001, 1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b1};
    vt[13] = '{1'b1, 16'h0000, 32'h00000001, 4'b0000, 1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  4'b0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready",  {31'h0, pready0},  32'h0);
    chk("reset_pslverr", {31'h0, pslverr0}, 32'h0);
    chk("reset_prdata",  prdata0,           32'h0);
    chk("reset_start",   {31'h0, start0},   32'h0);
    chk("reset_busy",    {31'h0, busyo0},   32'h0);
    chk("reset_memreq",  {31'h0, mreq0},    32'h0);
    chk("reset_memwe",   {31'h0, mwe0},     32'h0);
    chk("reset_wdata",   mwdata0,           32'h0);
    rst = 1'b0;

    sel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb,
          cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
      chk($sformatf("v%0d_ready_cycle", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vt[i].err});
      chk($sformatf("v%0d_prdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_mem_req", i), {31'h0, mreq}, {31'h0, vt[i].mreq});
      if (vt[i].mreq) begin
        chk($sformatf("v%0d_mem_we", i), {31'h0, mwe}, {31'h0, vt[i].mwe});
        chk($sformatf("v%0d_mem_addr", i), {26'h0, maddr}, {26'h0, vt[i].maddr});
        if (vt[i].mwe) chk($sformatf("v%0d_mem_be", i), {28'h0, mbe}, {28'h0, vt[i].mbe});
      end
      chk($sformatf("v%0d_start", i), {31'h0, st}, {31'h0, vt[i].st});
      chk($sformatf("v%0d_pready_one_cycle", i), {31'h0, ppready}, 32'h0);
      chk($sformatf("v%0d_busy_after", i), {31'h0, pbusy}, {31'h0, vt[i].st});
    end

    // Writes while the engine is busy.
    busy_in = 1'b1;
    repeat (2) @(posedge clk);
    apb(1'b1, 16'h0008, 32'h55555555, 4'b1111, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
`ifdef MATMUL_APB_PROT_EN
    chk("busy_memwr_pslverr", {31'h0, err},  32'h1);
    chk("busy_memwr_memreq",  {31'h0, mreq}, 32'h0);
`else
    chk("busy_memwr_pslverr", {31'h0, err},  32'h0);
    chk("busy_memwr_memreq",  {31'h0, mreq}, 32'h1);
    chk("busy_memwr_memwe",   {31'h0, mwe},  32'h1);
`endif
    apb(1'b1, 16'h0000, 32'h00000001, 4'b0001, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
`ifdef MATMUL_APB_PROT_EN
    chk("busy_start_pslverr", {31'h0, err}, 32'h1);
    chk("busy_start_pulse",   {31'h0, st},  32'h0);
`else
    chk("busy_start_pslverr", {31'h0, err}, 32'h0);
    chk("busy_start_pulse",   {31'h0, st},  32'h1);
`endif

    // Three wait states: STATUS with engine busy.
    sel = 1'b1;
    apb(1'b0, 16'h0004, 32'h0, 4'b0000, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
    chk("ws3_status_cycle",   cyc, 4);
    chk("ws3_status_prdata",  rd, 32'h1);
    chk("ws3_status_pslverr", {31'h0, err}, 32'h0);
    busy_in = 1'b0;

    apb(1'b1, 16'h000C, 32'hA5A5A5A5, 4'b1111, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
    chk("ws3_write_cycle",  cyc, 4);
    chk("ws3_write_memreq", {31'h0, mreq}, 32'h1);
    chk("ws3_write_addr",   {26'h0, maddr}, 32'd1);

    apb(1'b0, 16'h0010, 32'h0, 4'b0000, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
    chk("ws3_memrd_cycle",  cyc, 4);
    chk("ws3_memrd_prdata", rd, 32'h12345678);
    chk("ws3_memrd_addr",   {26'h0, maddr}, 32'd2);
    chk("ws3_memrd_we",     {31'h0, mwe}, 32'h0);

    // Abort: master drops the bus in access cycle 2 of a wait-stated write.
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C; pwdata = 32'h0F0F0F0F; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = pready3 | mreq3;
    @(posedge clk); #1;
    seen = seen | pready3 | mreq3;
    psel3 = 1'b0; penable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen = seen | pready3 | mreq3;
    end
    chk("abort_no_ready_no_write", {31'h0, seen}, 32'h0);

    // Reset in the middle of a wait-stated memory write.
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = mreq3;
    @(posedge clk); #1;
    seen = seen | mreq3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
    chk("midrst_pready",  {31'h0, pready3}, 32'h0);
    chk("midrst_prdata",  prdata3,          32'h0);
    chk("midrst_addr",    {26'h0, maddr3},  32'h0);
    chk("midrst_wdata",   mwdata3,          32'h0);
    chk("midrst_be",      {28'h0, mbe3},    32'h0);
    chk("midrst_busy",    {31'h0, busyo3},  32'h0);
    for (int k = 0; k < 6; k++) begin
      seen = seen | mreq3;
      @(posedge clk); #1;
    end
    chk("midrst_no_memreq", {31'h0, seen}, 32'h0);
    apb(1'b0, 16'h0004, 32'h0, 4'b0000, cyc, err, rd, mreq, mwe, maddr, mbe, st, ppready, pbusy);
    chk("postrst_cycle",  cyc, 4);
    chk("postrst_prdata", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
